// File: rtl/fb_port_arbiter_pkg.sv
// Shared constants and types for the frame-buffer port arbiter: frame geometry,
// grant codes (also used as the read-return tag) and round-robin history values.
package fb_port_arbiter_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_PIX_W  = 3;
    localparam int FB_DEPTH  = 19200;

    localparam logic RR_LAST_RND = 1'b0;
    localparam logic RR_LAST_DMP = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_RND  = 2'd2,
        GNT_DMP  = 2'd3
    } gnt_e;

    typedef struct packed {
        gnt_e kind;
        logic oob;
    } rd_tag_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of requester handshakes, memory port and stall counter around the arbiter.
// slave is the arbiter's view; master is the requester/memory environment view.
interface fb_port_arbiter_if
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int PIX_W  = FB_PIX_W
);

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [PIX_W-1:0]  disp_data;
    logic              disp_valid;

    logic              rnd_req;
    logic [ADDR_W-1:0] rnd_addr;
    logic [PIX_W-1:0]  rnd_wdata;
    logic              rnd_ack;

    logic              dmp_req;
    logic [ADDR_W-1:0] dmp_addr;
    logic              dmp_gnt;
    logic [PIX_W-1:0]  dmp_data;
    logic              dmp_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    logic [15:0]       stall_cnt;

    modport slave (
        input  disp_req, disp_addr,
        input  rnd_req, rnd_addr, rnd_wdata,
        input  dmp_req, dmp_addr,
        input  mem_rdata,
        output disp_data, disp_valid,
        output rnd_ack,
        output dmp_gnt, dmp_data, dmp_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_cnt
    );

    modport master (
        output disp_req, disp_addr,
        output rnd_req, rnd_addr, rnd_wdata,
        output dmp_req, dmp_addr,
        output mem_rdata,
        input  disp_data, disp_valid,
        input  rnd_ack,
        input  dmp_gnt, dmp_data, dmp_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_cnt
    );

endinterface

// File: rtl/fb_port_arbiter_rr_arb2.sv
// Two-way round-robin between renderer (bit 0) and dump (bit 1) for slots the display leaves free.
// History only moves when one of the two is actually granted.
module rr_arb2
    import fb_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req_i,
    input  logic       free_i,
    output logic [1:0] gnt_o
);

    logic rrLast_q, rrLast_d;

    always_comb begin
        gnt_o    = 2'b00;
        rrLast_d = rrLast_q;
        if (!clr && free_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (rrLast_q == RR_LAST_DMP) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (gnt_o != 2'b00) begin
                rrLast_d = gnt_o[1] ? RR_LAST_DMP : RR_LAST_RND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rrLast_q <= RR_LAST_DMP;
        end else begin
            rrLast_q <= rrLast_d;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame memory arbiter: display reads always win, renderer writes and dump
// reads share the remaining cycles round-robin; reads return one cycle later via a tag register.
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int PIX_W    = FB_PIX_W,
    parameter int FB_DEPTH = fb_port_arbiter_pkg::FB_DEPTH
) (
    input logic              clk,
    input logic              clr,
    fb_port_arbiter_if.slave bus
);

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(FB_DEPTH);

    logic [1:0]       rrGnt;
    gnt_e             grant;
    logic             dispOob, rndOob, dmpOob;
    rd_tag_t          tag_q, tag_d;
    logic [PIX_W-1:0] retData;
    logic [PIX_W-1:0] dispHold_q, dispHold_d, dmpHold_q, dmpHold_d;
    logic             dispValid, dmpValid;
    logic [15:0]      stall_q, stall_d;

    assign dispOob = {1'b0, bus.disp_addr} >= DepthLim;
    assign rndOob  = {1'b0, bus.rnd_addr}  >= DepthLim;
    assign dmpOob  = {1'b0, bus.dmp_addr}  >= DepthLim;

    rr_arb2 u_rr (
        .clk    (clk),
        .clr    (clr),
        .req_i  ({bus.dmp_req, bus.rnd_req}),
        .free_i (!bus.disp_req),
        .gnt_o  (rrGnt)
    );

    always_comb begin
        grant = GNT_NONE;
        if (!clr) begin
            if (bus.disp_req) begin
                grant = GNT_DISP;
            end else if (rrGnt[0]) begin
                grant = GNT_RND;
            end else if (rrGnt[1]) begin
                grant = GNT_DMP;
            end
        end
    end

    assign bus.rnd_ack = (grant == GNT_RND);
    assign bus.dmp_gnt = (grant == GNT_DMP);

    // Out-of-range reads are still granted and tagged, but never touch the RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        tag_d         = '{kind: GNT_NONE, oob: 1'b0};
        case (grant)
            GNT_DISP: begin
                bus.mem_en   = !dispOob;
                bus.mem_addr = bus.disp_addr;
                tag_d        = '{kind: GNT_DISP, oob: dispOob};
            end
            GNT_RND: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = !rndOob;
                bus.mem_addr  = bus.rnd_addr;
                bus.mem_wdata = bus.rnd_wdata;
            end
            GNT_DMP: begin
                bus.mem_en   = !dmpOob;
                bus.mem_addr = bus.dmp_addr;
                tag_d        = '{kind: GNT_DMP, oob: dmpOob};
            end
            default: begin
            end
        endcase
    end

    assign retData   = tag_q.oob ? '0 : bus.mem_rdata;
    assign dispValid = !clr && (tag_q.kind == GNT_DISP);
    assign dmpValid  = !clr && (tag_q.kind == GNT_DMP);

    assign dispHold_d = dispValid ? retData : dispHold_q;
    assign dmpHold_d  = dmpValid  ? retData : dmpHold_q;

    assign bus.disp_valid = dispValid;
    assign bus.dmp_valid  = dmpValid;
    assign bus.disp_data  = clr ? '0 : dispHold_d;
    assign bus.dmp_data   = clr ? '0 : dmpHold_d;

    // A stall is a display grant while another requester is left waiting.
    always_comb begin
        stall_d = stall_q;
        if ((grant == GNT_DISP) && (bus.rnd_req || bus.dmp_req) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            tag_q      <= '{kind: GNT_NONE, oob: 1'b0};
            dispHold_q <= '0;
            dmpHold_q  <= '0;
            stall_q    <= '0;
        end else begin
            tag_q      <= tag_d;
            dispHold_q <= dispHold_d;
            dmpHold_q  <= dmpHold_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench: a RAM responder, a per-cycle reference model of who owns the port,
// and directed scenarios with hand-computed expectations.
module tb_fb_port_arbiter;
    import fb_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fb_port_arbiter_if bus ();

    fb_port_arbiter dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Frame RAM: unwritten words read back as the preload pattern (addr*3)&7.
    logic [2:0] ram     [FB_DEPTH];
    bit         ramWr   [FB_DEPTH];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                if (int'(bus.mem_addr) < FB_DEPTH) begin
                    ram[int'(bus.mem_addr)]   <= bus.mem_wdata;
                    ramWr[int'(bus.mem_addr)] <= 1'b1;
                end
            end else if (int'(bus.mem_addr) < FB_DEPTH) begin
                bus.mem_rdata <= ramWr[int'(bus.mem_addr)] ? ram[int'(bus.mem_addr)]
                                                           : 3'((int'(bus.mem_addr) * 3) & 7);
            end else begin
                bus.mem_rdata <= 3'd0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, caller checks in the low phase.
    task automatic applyStimulus(input logic c,
                                 input logic dReq, input logic [15:0] dAddr,
                                 input logic rReq, input logic [15:0] rAddr, input logic [2:0] rData,
                                 input logic qReq, input logic [15:0] qAddr);
        @(posedge clk);
        #1;
        clr           = c;
        bus.disp_req  = dReq;
        bus.disp_addr = dAddr;
        bus.rnd_req   = rReq;
        bus.rnd_addr  = rAddr;
        bus.rnd_wdata = rData;
        bus.dmp_req   = qReq;
        bus.dmp_addr  = qAddr;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic c);
        applyStimulus(c, 1'b0, 16'd0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0);
    endtask

    // Reference model: who owns the port this cycle, what read comes back next cycle.
    logic [2:0] refMem   [FB_DEPTH];
    bit         refWr    [FB_DEPTH];
    logic       mLastDmp = 1'b1;
    gnt_e       mPend    = GNT_NONE;
    logic [2:0] mPendVal = 3'd0;
    logic [2:0] mHoldDisp = 3'd0;
    logic [2:0] mHoldDmp  = 3'd0;
    int         mStall    = 0;

    function automatic logic [2:0] refRead(input logic [15:0] a);
        if (int'(a) >= FB_DEPTH) return 3'd0;
        return refWr[int'(a)] ? refMem[int'(a)] : 3'((int'(a) * 3) & 7);
    endfunction

    always @(negedge clk) begin : compareProc
        gnt_e        served;
        logic        eMemEn, eDispV, eDmpV;
        logic [15:0] eAddr;
        logic [2:0]  eDispD, eDmpD;

        if (clr)                              served = GNT_NONE;
        else if (bus.disp_req)                served = GNT_DISP;
        else if (bus.rnd_req && bus.dmp_req)  served = mLastDmp ? GNT_RND : GNT_DMP;
        else if (bus.rnd_req)                 served = GNT_RND;
        else if (bus.dmp_req)                 served = GNT_DMP;
        else                                  served = GNT_NONE;

        eAddr  = (served == GNT_DISP) ? bus.disp_addr :
                 (served == GNT_RND)  ? bus.rnd_addr  :
                 (served == GNT_DMP)  ? bus.dmp_addr  : 16'd0;
        eMemEn = (served == GNT_RND) ||
                 (((served == GNT_DISP) || (served == GNT_DMP)) && (int'(eAddr) < FB_DEPTH));
        eDispV = !clr && (mPend == GNT_DISP);
        eDmpV  = !clr && (mPend == GNT_DMP);
        eDispD = clr ? 3'd0 : (eDispV ? mPendVal : mHoldDisp);
        eDmpD  = clr ? 3'd0 : (eDmpV  ? mPendVal : mHoldDmp);

        checkOutput("rnd_ack",    32'(bus.rnd_ack),    32'(served == GNT_RND));
        checkOutput("dmp_gnt",    32'(bus.dmp_gnt),    32'(served == GNT_DMP));
        checkOutput("mem_en",     32'(bus.mem_en),     32'(eMemEn));
        checkOutput("mem_we",     32'(bus.mem_we),     32'((served == GNT_RND) && (int'(eAddr) < FB_DEPTH)));
        if (eMemEn) checkOutput("mem_addr", 32'(bus.mem_addr), 32'(eAddr));
        if (served == GNT_RND && int'(eAddr) < FB_DEPTH)
            checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(bus.rnd_wdata));
        checkOutput("disp_valid", 32'(bus.disp_valid), 32'(eDispV));
        checkOutput("dmp_valid",  32'(bus.dmp_valid),  32'(eDmpV));
        checkOutput("disp_data",  32'(bus.disp_data),  32'(eDispD));
        checkOutput("dmp_data",   32'(bus.dmp_data),   32'(eDmpD));
        checkOutput("stall_cnt",  32'(bus.stall_cnt),  32'(mStall));

        if (clr) begin
            mLastDmp  = 1'b1;
            mPend     = GNT_NONE;
            mHoldDisp = 3'd0;
            mHoldDmp  = 3'd0;
            mStall    = 0;
        end else begin
            mHoldDisp = eDispD;
            mHoldDmp  = eDmpD;
            mPend     = ((served == GNT_DISP) || (served == GNT_DMP)) ? served : GNT_NONE;
            mPendVal  = refRead(eAddr);
            if (served == GNT_RND && int'(eAddr) < FB_DEPTH) begin
                refMem[int'(eAddr)] = bus.rnd_wdata;
                refWr[int'(eAddr)]  = 1'b1;
            end
            if (served == GNT_RND) mLastDmp = 1'b0;
            if (served == GNT_DMP) mLastDmp = 1'b1;
            if (served == GNT_DISP && (bus.rnd_req || bus.dmp_req) && mStall < 65535) mStall++;
        end
    end

    initial begin
        bus.disp_req  = 1'b0;
        bus.disp_addr = 16'd0;
        bus.rnd_req   = 1'b0;
        bus.rnd_addr  = 16'd0;
        bus.rnd_wdata = 3'd0;
        bus.dmp_req   = 1'b0;
        bus.dmp_addr  = 16'd0;

        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);
        checkOutput("rst_stall", 32'(bus.stall_cnt), 32'd0);
        checkOutput("rst_disp_valid", 32'(bus.disp_valid), 32'd0);

        // Display streams 0..99 while the renderer waits the whole time.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 1'b1, 16'd500, 3'd1, 1'b0, 16'd0);
            checkOutput("t2_rnd_held", 32'(bus.rnd_ack), 32'd0);
            if (i > 0) begin
                checkOutput("t2_disp_valid", 32'(bus.disp_valid), 32'd1);
                checkOutput("t2_disp_data", 32'(bus.disp_data), 32'(((i - 1) * 3) & 7));
            end
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd500, 3'd1, 1'b0, 16'd0);
        checkOutput("t2_last_valid", 32'(bus.disp_valid), 32'd1);
        checkOutput("t2_last_data", 32'(bus.disp_data), 32'd1);
        checkOutput("t2_stall", 32'(bus.stall_cnt), 32'd100);
        checkOutput("t2_rnd_ack", 32'(bus.rnd_ack), 32'd1);

        // Dump read in flight when clr arrives: its return must be swallowed.
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 3'd0, 1'b1, 16'd10);
        checkOutput("t1_dmp_gnt", 32'(bus.dmp_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 16'd20, 3'd3, 1'b0, 16'd0);
        checkOutput("t1_dmp_valid", 32'(bus.dmp_valid), 32'd0);
        checkOutput("t1_dmp_data", 32'(bus.dmp_data), 32'd0);
        checkOutput("t1_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("t1_rnd_ack", 32'(bus.rnd_ack), 32'd0);
        idleCycle(1'b0);
        checkOutput("t1_after_valid", 32'(bus.dmp_valid), 32'd0);
        checkOutput("t1_after_stall", 32'(bus.stall_cnt), 32'd0);

        // Renderer and dump both pending: strict alternation starting with the renderer.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd600, 3'd2, 1'b1, 16'd700);
            checkOutput("t3_rnd_ack", 32'(bus.rnd_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("t3_dmp_gnt", 32'(bus.dmp_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 2 || k == 4) checkOutput("t3_dmp_data", 32'(bus.dmp_data), 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd600, 3'd2, 1'b1, 16'd700);
        checkOutput("t3_rr_after", 32'(bus.rnd_ack), 32'd1);
        checkOutput("t3_dmp_valid", 32'(bus.dmp_valid), 32'd1);
        checkOutput("t3_dmp_data_last", 32'(bus.dmp_data), 32'd4);

        // Out-of-range write is acknowledged but dropped; out-of-range read returns 0.
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd19200, 3'd5, 1'b0, 16'd0);
        checkOutput("t4_rnd_ack", 32'(bus.rnd_ack), 32'd1);
        checkOutput("t4_mem_we", 32'(bus.mem_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 3'd0, 1'b1, 16'd19200);
        checkOutput("t4_dmp_gnt", 32'(bus.dmp_gnt), 32'd1);
        checkOutput("t4_mem_en", 32'(bus.mem_en), 32'd0);
        idleCycle(1'b0);
        checkOutput("t4_dmp_valid", 32'(bus.dmp_valid), 32'd1);
        checkOutput("t4_dmp_data", 32'(bus.dmp_data), 32'd0);

        // Write then immediate display readback.
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd42, 3'd6, 1'b0, 16'd0);
        checkOutput("t5_mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("t5_mem_addr", 32'(bus.mem_addr), 32'd42);
        applyStimulus(1'b0, 1'b1, 16'd42, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0);
        idleCycle(1'b0);
        checkOutput("t5_disp_valid", 32'(bus.disp_valid), 32'd1);
        checkOutput("t5_disp_data", 32'(bus.disp_data), 32'd6);
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd43, 3'd2, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'd43, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0);
        idleCycle(1'b0);
        checkOutput("t5_disp_data43", 32'(bus.disp_data), 32'd2);

        // Long stall run: the counter must pin at its maximum.
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i % 100), 1'b1, 16'd800, 3'd7, 1'b0, 16'd0);
        end
        checkOutput("t6_stall_sat", 32'(bus.stall_cnt), 32'h0000FFFF);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b1, 16'd800, 3'd7, 1'b0, 16'd0);
        checkOutput("t6_stall_stick", 32'(bus.stall_cnt), 32'h0000FFFF);
        idleCycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
